// File: rtl/spi_frame_streamer.sv
// SPI frame streamer: header, address, channel payload, optional checksum.
// Define CHECKSUM_EN to append a mod-256 checksum byte after the payload.
module spi_frame_streamer #(
  parameter int          NUM_CH     = 8,
  parameter int          CH_BYTES   = 4,
  parameter logic [7:0]  START_ADDR = 8'h00,
  parameter logic [7:0]  HEADER_CMD = 8'h02
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_CH*CH_BYTES*8-1:0] data,
  input  logic                         data_ready,
  input  logic                         di_req,
  input  logic                         write_ack,
  output logic [7:0]                   byte_out,
  output logic                         wren,
  output logic                         busy,
  output logic                         frame_done,
  output logic [7:0]                   overrun_count
);

  localparam int PL_BYTES = NUM_CH * CH_BYTES;
`ifdef CHECKSUM_EN
  localparam int FRAME_LEN = PL_BYTES + 3;
`else
  localparam int FRAME_LEN = PL_BYTES + 2;
`endif
  localparam int IW = $clog2(FRAME_LEN + 1);
  localparam logic [IW-1:0] LAST   = IW'(FRAME_LEN);
  localparam logic [IW-1:0] IDX_AD = IW'(1);
`ifdef CHECKSUM_EN
  localparam logic [IW-1:0] CK_IDX = IW'(FRAME_LEN - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, HEADER, ADDR, PAYLOAD, CKSUM, DONE
  } state_t;

  state_t              state_q;
  logic [7:0]          byte_q;
  logic                wren_q;
  logic                busy_q;
  logic                done_q;
  logic [7:0]          ovr_q;
  logic [IW-1:0]       idx_q;
  logic                ack_q;
  logic [PL_BYTES*8-1:0] snap_q;
`ifdef CHECKSUM_EN
  logic [7:0]          cks_q;
`endif

  logic          ack_edge;
  logic          load_ok;
  logic [IW-1:0] idx_d;
  logic [7:0]    pay_byte;
  logic [7:0]    byte_d;

  // Acknowledge edge, load permission and the byte for the current index.
  always_comb begin
    ack_edge = write_ack & ~ack_q & wren_q &
               (state_q != IDLE) & (state_q != DONE);
    load_ok  = ~wren_q & di_req & busy_q & (state_q != DONE);
    idx_d    = idx_q + 1'b1;
    pay_byte = 8'h00;
    for (int i = 0; i < PL_BYTES; i++) begin
      if (idx_q == IW'(i + 2)) pay_byte = snap_q[i*8 +: 8];
    end
    byte_d = pay_byte;
    if (idx_q == IDX_AD) byte_d = START_ADDR;
`ifdef CHECKSUM_EN
    if (idx_q == CK_IDX) byte_d = cks_q;
`endif
  end

  // Frame sequencer with registered outputs and overrun counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      byte_q  <= 8'h00;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 8'h00;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      snap_q  <= '0;
`ifdef CHECKSUM_EN
      cks_q   <= 8'h00;
`endif
    end else begin
      ack_q  <= write_ack;
      done_q <= 1'b0;
      if (data_ready && state_q != IDLE && ovr_q != 8'hFF)
        ovr_q <= ovr_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (data_ready) begin
            snap_q  <= data;
            byte_q  <= HEADER_CMD;
            wren_q  <= 1'b1;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= HEADER;
`ifdef CHECKSUM_EN
            cks_q   <= START_ADDR;
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end
        default: begin
          if (ack_edge) begin
            wren_q <= 1'b0;
            idx_q  <= idx_d;
            if (idx_d == LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (idx_d == IDX_AD) begin
              state_q <= ADDR;
`ifdef CHECKSUM_EN
            end else if (idx_d == CK_IDX) begin
              state_q <= CKSUM;
`endif
            end else begin
              state_q <= PAYLOAD;
            end
          end else if (load_ok) begin
            byte_q <= byte_d;
            wren_q <= 1'b1;
`ifdef CHECKSUM_EN
            if (state_q == PAYLOAD) cks_q <= cks_q + byte_d;
`endif
          end
        end
      endcase
    end
  end

  assign byte_out      = byte_q;
  assign wren          = wren_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_spi_frame_streamer.sv
// Scoreboard bench for spi_frame_streamer with a handshaking SPI core model.
// Expected bytes are derived from the frame format rules.
module tb_spi_frame_streamer;

  localparam int          NCH  = 2;
  localparam int          CHB  = 4;
  localparam int          NB   = NCH * CHB;
  localparam logic [7:0]  SADR = 8'h00;
  localparam logic [7:0]  HCMD = 8'h02;

  logic             clock = 0;
  logic             reset_n;
  logic [NB*8-1:0]  data;
  logic             data_ready;
  logic             di_req;
  logic             write_ack;
  logic [7:0]       byte_out;
  logic             wren;
  logic             busy;
  logic             frame_done;
  logic [7:0]       overrun_count;

  spi_frame_streamer #(
    .NUM_CH(NCH), .CH_BYTES(CHB)
  ) dut (
    .clock(clock), .reset_n(reset_n), .data(data),
    .data_ready(data_ready), .di_req(di_req),
    .write_ack(write_ack), .byte_out(byte_out),
    .wren(wren), .busy(busy), .frame_done(frame_done),
    .overrun_count(overrun_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int rx_cnt = 0;
  int done_cnt = 0;
  int exp_frames = 0;
  int ov_exp = 0;
  bit spi_en = 1;
  bit sim_mode = 0;
  logic fd_prev = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SPI core model plus byte monitor
  initial begin
    logic [7:0] e;
    int n;
    write_ack = 0;
    di_req = 0;
    forever begin
      @(negedge clock);
      if (spi_en && reset_n && wren) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL byte_unexpected got %02h expected none", byte_out);
        end else begin
          e = exp_q.pop_front();
          chk("byte", byte_out, e);
        end
        repeat ($urandom_range(0, 2)) @(negedge clock);
        write_ack = 1;
        if (sim_mode) di_req = 1;
        @(negedge clock);
        write_ack = 0;
        if (reset_n) chk("ack_clears_wren", wren, 0);
        if (!sim_mode) begin
          repeat ($urandom_range(0, 2)) @(negedge clock);
          di_req = 1;
        end
        n = 0;
        while (!wren && busy && n < 30) begin
          @(negedge clock);
          n++;
        end
        if (n >= 30) begin
          checks++;
          errors++;
          $display("FAIL next_byte_timeout got wren=0 expected wren=1");
        end
        di_req = 0;
      end
    end
  end

  // frame_done pulse monitor
  always @(negedge clock) begin
    if (frame_done) begin
      done_cnt++;
      chk("frame_done_width", fd_prev, 0);
    end
    fd_prev = frame_done;
  end

  task automatic push_frame(input logic [NB*8-1:0] d);
    int sum;
    sum = SADR;
    exp_q.push_back(HCMD);
    exp_q.push_back(SADR);
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back(d[8*i +: 8]);
      sum += d[8*i +: 8];
    end
`ifdef CHECKSUM_EN
    exp_q.push_back(8'(sum % 256));
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy=1 expected busy=0");
    end
  endtask

  task automatic start_frame(input logic [NB*8-1:0] d);
    wait_idle();
    @(negedge clock);
    data = d;
    data_ready = 1;
    push_frame(d);
    exp_frames++;
    @(negedge clock);
    data_ready = 0;
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_cnt < target && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout got %0d expected %0d", rx_cnt, target);
    end
  endtask

  task automatic end_frame(input string nm);
    wait_idle();
    repeat (2) @(negedge clock);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done_cnt"}, done_cnt, exp_frames);
    chk({nm, "_bytes_left"}, exp_q.size(), 0);
  endtask

  task automatic pulse_dr();
    data_ready = 1;
    if (busy && ov_exp < 255) ov_exp++;
    @(negedge clock);
    data_ready = 0;
    @(negedge clock);
  endtask

  initial begin
    int base;
    reset_n = 0;
    data = '0;
    data_ready = 0;
    repeat (3) @(negedge clock);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_wren", wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun_count, 0);
    reset_n = 1;
    repeat (2) @(negedge clock);

    start_frame(64'h8877665544332211);
    end_frame("basic");

    base = rx_cnt;
    start_frame(64'h0123456789ABCDEF);
    wait_rx(base + 3);
    pulse_dr();
    pulse_dr();
    end_frame("overrun");
    chk("overrun_two", overrun_count, ov_exp);

    base = rx_cnt;
    start_frame(64'h8877665544332211);
    wait_rx(base + 2);
    data = '0;
    end_frame("snapshot");

    sim_mode = 1;
    start_frame(64'hDEADBEEFCAFEF00D);
    end_frame("simultaneous");

    for (int k = 0; k < 20; k++) begin
      sim_mode = 1'($urandom_range(0, 1));
      start_frame({$urandom, $urandom});
      end_frame("random");
    end
    sim_mode = 0;

    base = rx_cnt;
    start_frame(64'h8877665544332211);
    wait_rx(base + 5);
    #2;
    reset_n = 0;
    #1;
    chk("abort_byte_out", byte_out, 0);
    chk("abort_wren", wren, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_done", frame_done, 0);
    chk("abort_overrun", overrun_count, 0);
    exp_frames--;
    ov_exp = 0;
    exp_q.delete();
    repeat (10) @(negedge clock);
    reset_n = 1;
    repeat (20) @(negedge clock);
    chk("abort_no_done", done_cnt, exp_frames);
    chk("abort_stays_idle", busy, 0);
    start_frame(64'h8877665544332211);
    end_frame("after_reset");

    spi_en = 0;
    start_frame(64'h1122334455667788);
    for (int k = 0; k < 300; k++) pulse_dr();
    chk("overrun_sat", overrun_count, ov_exp);
    chk("overrun_sat_255", overrun_count, 255);
    spi_en = 1;
    end_frame("saturate");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
